design1_wrapper: RTL and testbench
==================================

# design1_wrapper

AXI4-Lite register front end of the AES-CTR peripheral. Holds the plaintext, three 192-bit keys, a key select, the 128-bit counter block and the ciphertext. On a start command it launches one block operation on an external AES-192 core, then produces CT = PT XOR E(K, ST) and increments ST. The cipher core lives outside this block and is reached through a simple start/done port.

## Interface
Parameters:
- ADDR_W, 8, AXI4-Lite byte-address width; only offsets 0x00–0x80 are decoded.

Ports:
- aclk_0  in  1  single clock.
- aresetn_0  in  1  asynchronous, active-low reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel; wstrb is ignored and full-word writes are assumed.
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- core_start  out  1  one-cycle launch pulse to the cipher core.
- core_key  out  192  selected key, latched at launch.
- core_block  out  128  counter block (ST), latched at launch.
- core_done  in  1  one-cycle pulse from the core: result valid.
- core_result  in  128  E(core_key, core_block).

## Operation
- Register map (byte offsets). In every multi-word field, the lowest address holds bits [31:0].
  - 0x00 START (bit0 only).
  - 0x04–0x10 PT.
  - 0x14–0x28 KEY0.
  - 0x2C DONE (read-only, bit0).
  - 0x30–0x3C CT (read-only).
  - 0x40–0x4C ST.
  - 0x50–0x64 KEY1.
  - 0x68–0x7C KEY2.
  - 0x80 KEY_SEL (bits[1:0]).
- KEY_SEL value 0, 1 or 2 selects KEY0, KEY1 or KEY2. Value 3 selects KEY0.
- Launch condition: a write to START with bit0=1 while the stored START bit0 was 0 (rising edge) and the block is not busy.
- On launch:
  - core_key and core_block are latched.
  - DONE is cleared and busy is set.
  - core_start pulses.
- A START rising edge while busy is ignored; the START register still updates.
- On core_done while busy:
  - CT ← PT XOR core_result.
  - DONE ← 1 and busy ← 0.
  - ST ← ST+1, modulo 2^128 (wraps from all-ones to 0).
- core_done while not busy is ignored.
- Writes to PT, keys, ST or KEY_SEL while busy update the registers but do not affect the in-flight operation.
- A host ST write in the same cycle as the completion increment: the host write wins.
- Writes to read-only or unmapped offsets are dropped with bresp OKAY.
- Reads of unmapped offsets return 0 with rresp OKAY.
- All write-side registers read back their stored values.
- DONE reads as {31'b0, done}; KEY_SEL reads as {30'b0, sel}.

## Timing
- Reset (asynchronous, aresetn_0 low) values:
  - All registers, busy and DONE are 0.
  - awready, wready, bvalid, arready, rvalid and core_start are 0.
  - bresp and rresp are 00.
- Reset mid-operation aborts the operation. A later core_done is ignored because busy is 0.
- Write channel:
  - The write is accepted when awvalid and wvalid are both high: awready and wready pulse together for 1 cycle.
  - The register updates on that edge.
  - bvalid rises the next cycle and holds until bready.
  - No new write is accepted while bvalid is high.
- Read channel:
  - arready pulses for 1 cycle on arvalid.
  - rvalid rises the next cycle with rdata and holds until rready.
  - No new read is accepted while rvalid is high.
- Read and write may proceed in the same cycle.
- core_start is asserted the cycle after the START write is accepted, for exactly 1 cycle.
- CT, DONE and ST update on the edge that samples core_done. A read issued on the following cycle returns the new values.

## Structure
- Shared package holds the offset constants (START, PT, KEY0, DONE, CT, ST, KEY1, KEY2, KEY_SEL) and the word counts (PT 4, KEY 6, ST 4, CT 4).
- Sub-module axil_slave_if implements the AXI4-Lite handshake and exposes wr_en/wr_addr/wr_data and rd_addr/rd_data.
- The top level holds the register file and the launch/complete FSM with states IDLE and BUSY.

## Test plan
- Reset: hold aresetn_0 low for 175 ns → every register reads 0 and core_start stays low.
- KEY0/1/2 readback:
  - Write words 28aed2a6, 2b7e1516, 09cf4f3c, abf71588, 28aed2a6, 2b7e1516 to each key.
  - Read back → identical values.
  - core_key = 2b7e1516_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6 with KEY_SEL=0.
- CTR block:
  - Write PT words 66667777, 44445555, 22223333, 00001111 and ST words 3243f6a8, 885a308d, 313198a2, e0370734.
  - Write START 0, then 1, then 0. The bench core returns result = all-ones after 20 cycles.
  - Expect: one core_start pulse; DONE=1; CT words = 99998888, bbbbaaaa, ddddcccc, ffffeeee; ST word0 = 3243f6a9.
- Busy guard: a START 0→1 issued during BUSY → no second core_start pulse.
- ST wrap: ST = all-ones, run one block → ST reads 0 in all four words.
- Key select: KEY_SEL=2 with distinct KEY2 contents → core_key equals KEY2. KEY_SEL=3 → core_key equals KEY0.

Source files
------------

// File: rtl/design1_wrapper_pkg.sv
// Shared register-map constants and decode helpers for the AES-CTR register front end.
package design1_wrapper_pkg;

   localparam logic [7:0] START_OFF  = 8'h00;
   localparam logic [7:0] PT_OFF     = 8'h04;
   localparam logic [7:0] KEY0_OFF   = 8'h14;
   localparam logic [7:0] DONE_OFF   = 8'h2C;
   localparam logic [7:0] CT_OFF     = 8'h30;
   localparam logic [7:0] ST_OFF     = 8'h40;
   localparam logic [7:0] KEY1_OFF   = 8'h50;
   localparam logic [7:0] KEY2_OFF   = 8'h68;
   localparam logic [7:0] KEYSEL_OFF = 8'h80;
   localparam logic [7:0] MAX_OFF    = 8'h80;

   localparam int unsigned PT_WORDS  = 4;
   localparam int unsigned KEY_WORDS = 6;
   localparam int unsigned ST_WORDS  = 4;
   localparam int unsigned CT_WORDS  = 4;

   // True when word index w falls inside the n-word field starting at byte offset base.
   function automatic logic in_field(input logic [5:0] w, input logic [7:0] base,
                                     input int unsigned n);
      int unsigned wi;
      int unsigned bi;
      wi = 32'(w);
      bi = 32'(base[7:2]);
      return (wi >= bi) && (wi < bi + n);
   endfunction

   function automatic int unsigned field_idx(input logic [5:0] w, input logic [7:0] base);
      return 32'(w) - 32'(base[7:2]);
   endfunction

endpackage

// File: rtl/design1_wrapper_if.sv
// AXI4-Lite bus bundle for the register front end.
interface design1_wrapper_if #(parameter int ADDR_W = 8);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/design1_wrapper_axil_slave_if.sv
// AXI4-Lite slave handshake: turns bus transactions into single-cycle register accesses.
module axil_slave_if #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   design1_wrapper_if.slave  s_axi,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [31:0]       rd_data
);

   logic        awready;
   logic        bvalid;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic        rd_en;
   logic        unused;

   assign wr_en   = awready && s_axi.awvalid && s_axi.wvalid;
   assign rd_en   = arready && s_axi.arvalid;
   assign wr_addr = s_axi.awaddr;
   assign wr_data = s_axi.wdata;
   assign rd_addr = s_axi.araddr;
   assign unused  = ^s_axi.wstrb;

   assign s_axi.awready = awready;
   assign s_axi.wready  = awready;
   assign s_axi.bvalid  = bvalid;
   assign s_axi.bresp   = '0;
   assign s_axi.arready = arready;
   assign s_axi.rvalid  = rvalid;
   assign s_axi.rdata   = rdata;
   assign s_axi.rresp   = '0;

   // Ready pulses one cycle; the pending response blocks the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= 1'b0;
         bvalid  <= 1'b0;
         arready <= 1'b0;
         rvalid  <= 1'b0;
         rdata   <= '0;
      end else begin
         awready <= s_axi.awvalid && s_axi.wvalid && !awready && !bvalid;
         if (wr_en)
            bvalid <= 1'b1;
         else if (s_axi.bready)
            bvalid <= 1'b0;
         arready <= s_axi.arvalid && !arready && !rvalid;
         if (rd_en) begin
            rvalid <= 1'b1;
            rdata  <= rd_data;
         end else if (s_axi.rready) begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/design1_wrapper.sv
// AES-CTR register front end: register file plus launch/complete control for an external AES-192 core.
module design1_wrapper
   import design1_wrapper_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic             aclk_0,
   input  logic             aresetn_0,
   design1_wrapper_if.slave s_axi,
   output logic             core_start,
   output logic [191:0]     core_key,
   output logic [127:0]     core_block,
   input  logic             core_done,
   input  logic [127:0]     core_result
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;

   logic [0:0]   state;
   logic         start_bit;
   logic         done;
   logic [1:0]   key_sel;
   logic [127:0] pt, ct, st;
   logic [191:0] key0, key1, key2, sel_key;
   logic [5:0]   wr_w, rd_w;
   logic         wr_ok, rd_ok, launch, finish, unused;

   axil_slave_if #(.ADDR_W(ADDR_W)) u_axil (
      .clk     (aclk_0),
      .rst_n   (aresetn_0),
      .s_axi   (s_axi),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign wr_w   = wr_addr[7:2];
   assign rd_w   = rd_addr[7:2];
   assign wr_ok  = wr_en && (wr_addr <= ADDR_W'(MAX_OFF));
   assign rd_ok  = rd_addr <= ADDR_W'(MAX_OFF);
   assign unused = ^{wr_addr[1:0], rd_addr[1:0]};

   assign launch = wr_ok && (wr_w == START_OFF[7:2]) && wr_data[0] && !start_bit && (state == IDLE);
   assign finish = core_done && (state == BUSY);

   always_comb begin
      case (key_sel)
         2'd1:    sel_key = key1;
         2'd2:    sel_key = key2;
         default: sel_key = key0;
      endcase
   end

   // Host writes come after the completion update so an ST write in the same cycle wins.
   always_ff @(posedge aclk_0 or negedge aresetn_0) begin
      if (!aresetn_0) begin
         state      <= IDLE;
         start_bit  <= 1'b0;
         done       <= 1'b0;
         key_sel    <= '0;
         pt         <= '0;
         ct         <= '0;
         st         <= '0;
         key0       <= '0;
         key1       <= '0;
         key2       <= '0;
         core_start <= 1'b0;
         core_key   <= '0;
         core_block <= '0;
      end else begin
         core_start <= launch;
         if (launch) begin
            core_key   <= sel_key;
            core_block <= st;
            done       <= 1'b0;
            state      <= BUSY;
         end else if (finish) begin
            ct    <= pt ^ core_result;
            st    <= st + 128'd1;
            done  <= 1'b1;
            state <= IDLE;
         end
         if (wr_ok) begin
            if (wr_w == START_OFF[7:2])
               start_bit <= wr_data[0];
            if (wr_w == KEYSEL_OFF[7:2])
               key_sel <= wr_data[1:0];
            if (in_field(wr_w, PT_OFF, PT_WORDS))
               pt[field_idx(wr_w, PT_OFF)*32 +: 32] <= wr_data;
            if (in_field(wr_w, ST_OFF, ST_WORDS))
               st[field_idx(wr_w, ST_OFF)*32 +: 32] <= wr_data;
            if (in_field(wr_w, KEY0_OFF, KEY_WORDS))
               key0[field_idx(wr_w, KEY0_OFF)*32 +: 32] <= wr_data;
            if (in_field(wr_w, KEY1_OFF, KEY_WORDS))
               key1[field_idx(wr_w, KEY1_OFF)*32 +: 32] <= wr_data;
            if (in_field(wr_w, KEY2_OFF, KEY_WORDS))
               key2[field_idx(wr_w, KEY2_OFF)*32 +: 32] <= wr_data;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (rd_ok) begin
         if (rd_w == START_OFF[7:2])  rd_data = {31'b0, start_bit};
         if (rd_w == DONE_OFF[7:2])   rd_data = {31'b0, done};
         if (rd_w == KEYSEL_OFF[7:2]) rd_data = {30'b0, key_sel};
         if (in_field(rd_w, PT_OFF, PT_WORDS))    rd_data = pt[field_idx(rd_w, PT_OFF)*32 +: 32];
         if (in_field(rd_w, CT_OFF, CT_WORDS))    rd_data = ct[field_idx(rd_w, CT_OFF)*32 +: 32];
         if (in_field(rd_w, ST_OFF, ST_WORDS))    rd_data = st[field_idx(rd_w, ST_OFF)*32 +: 32];
         if (in_field(rd_w, KEY0_OFF, KEY_WORDS)) rd_data = key0[field_idx(rd_w, KEY0_OFF)*32 +: 32];
         if (in_field(rd_w, KEY1_OFF, KEY_WORDS)) rd_data = key1[field_idx(rd_w, KEY1_OFF)*32 +: 32];
         if (in_field(rd_w, KEY2_OFF, KEY_WORDS)) rd_data = key2[field_idx(rd_w, KEY2_OFF)*32 +: 32];
      end
   end

endmodule

// File: tb/tb_design1_wrapper.sv
// Bench for design1_wrapper: register table, CTR block runs against a behavioural core, corner sequences.
module tb_design1_wrapper;
   import design1_wrapper_pkg::*;

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] data;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      string       name;
   } exp_t;

   logic         aclk_0 = 1'b0;
   logic         aresetn_0 = 1'b0;
   logic         core_start;
   logic [191:0] core_key;
   logic [127:0] core_block;
   logic         core_done = 1'b0;
   logic [127:0] core_result = '0;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   exp_t        exp_q[$];
   vec_t        vt[$];

   // Behavioural core state
   int unsigned  starts = 0;
   int unsigned  dones = 0;
   int unsigned  pulse_err = 0;
   logic [191:0] key_seen = '0;
   logic [127:0] blk_seen = '0;
   logic [127:0] res_val = '1;
   bit           inject = 1'b0;

   design1_wrapper_if #(.ADDR_W(8)) s_axi ();

   design1_wrapper #(.ADDR_W(8)) dut (
      .aclk_0      (aclk_0),
      .aresetn_0   (aresetn_0),
      .s_axi       (s_axi),
      .core_start  (core_start),
      .core_key    (core_key),
      .core_block  (core_block),
      .core_done   (core_done),
      .core_result (core_result)
   );

   always #5ns aclk_0 = ~aclk_0;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog expired");
   end

   // Core answers 20 cycles after a launch; a spurious done can be injected while idle.
   initial begin
      int  cnt;
      bit  pend;
      logic prev;
      cnt = 0;
      pend = 1'b0;
      prev = 1'b0;
      forever begin
         @(negedge aclk_0);
         core_done = 1'b0;
         if (core_start) begin
            starts++;
            if (prev) pulse_err++;
            key_seen = core_key;
            blk_seen = core_block;
            if (!pend) begin
               pend = 1'b1;
               cnt = 20;
            end
         end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
               pend = 1'b0;
               core_result = res_val;
               core_done = 1'b1;
               dones++;
            end
         end else if (inject) begin
            inject = 1'b0;
            core_result = '0;
            core_done = 1'b1;
         end
         prev = core_start;
      end
   end

   function automatic void check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endfunction

   function automatic void fail_timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no handshake within bound, required one", name);
   endfunction

   function automatic void add(input bit wr, input logic [7:0] a, input logic [31:0] d, input string n);
      vt.push_back('{wr, a, d, n});
   endfunction

   task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
      int n;
      @(negedge aclk_0);
      s_axi.awaddr  = a;
      s_axi.wdata   = d;
      s_axi.wstrb   = '1;
      s_axi.awvalid = 1'b1;
      s_axi.wvalid  = 1'b1;
      n = 0;
      while (!s_axi.awready && n < 50) begin
         @(negedge aclk_0);
         n++;
      end
      if (!s_axi.awready) begin
         fail_timeout($sformatf("awready_%02h", a));
         s_axi.awvalid = 1'b0;
         s_axi.wvalid  = 1'b0;
         return;
      end
      @(posedge aclk_0);
      #1ns;
      s_axi.awvalid = 1'b0;
      s_axi.wvalid  = 1'b0;
      s_axi.bready  = 1'b1;
      n = 0;
      while (!s_axi.bvalid && n < 50) begin
         @(negedge aclk_0);
         n++;
      end
      if (!s_axi.bvalid) fail_timeout($sformatf("bvalid_%02h", a));
      else check($sformatf("bresp_%02h", a), 192'(s_axi.bresp), 192'(0));
      @(posedge aclk_0);
      #1ns;
      s_axi.bready = 1'b0;
   endtask

   // Expected value is queued at issue time and popped when rvalid appears.
   task automatic check_read(input logic [7:0] a, input logic [31:0] exp, input string name);
      int   n;
      exp_t e;
      exp_q.push_back('{exp, name});
      @(negedge aclk_0);
      s_axi.araddr  = a;
      s_axi.arvalid = 1'b1;
      n = 0;
      while (!s_axi.arready && n < 50) begin
         @(negedge aclk_0);
         n++;
      end
      if (!s_axi.arready) begin
         fail_timeout({name, "_arready"});
         s_axi.arvalid = 1'b0;
         void'(exp_q.pop_front());
         return;
      end
      @(posedge aclk_0);
      #1ns;
      s_axi.arvalid = 1'b0;
      n = 0;
      while (!s_axi.rvalid && n < 50) begin
         @(negedge aclk_0);
         n++;
      end
      e = exp_q.pop_front();
      if (!s_axi.rvalid) begin
         fail_timeout({e.name, "_rvalid"});
         return;
      end
      check(e.name, 192'(s_axi.rdata), 192'(e.data));
      s_axi.rready = 1'b1;
      @(posedge aclk_0);
      #1ns;
      s_axi.rready = 1'b0;
   endtask

   task automatic wait_dones(input int unsigned target, input string name);
      int n;
      n = 0;
      while (dones < target && n < 200) begin
         @(negedge aclk_0);
         n++;
      end
      if (dones < target) fail_timeout(name);
      @(negedge aclk_0);
   endtask

   task automatic run_block(input string name);
      int unsigned d0;
      d0 = dones;
      axi_write(START_OFF, 32'h0);
      axi_write(START_OFF, 32'h1);
      axi_write(START_OFF, 32'h0);
      wait_dones(d0 + 1, name);
   endtask

   task automatic write_field(input logic [7:0] base, input int unsigned n, input logic [191:0] v);
      for (int unsigned i = 0; i < n; i++)
         axi_write(base + 8'(i*4), v[i*32 +: 32]);
   endtask

   initial begin
      logic [31:0]  kw [6];
      logic [191:0] k0_exp, k1_v, k2_v;
      logic [127:0] pt_v, st_v, ct_exp;
      int unsigned  s0, d0;

      s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0;
      s_axi.wvalid = 1'b0; s_axi.bready = 1'b0; s_axi.araddr = '0; s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b0;

      #175ns;
      @(negedge aclk_0);
      check("rst_awready", 192'(s_axi.awready), 192'(0));
      check("rst_bvalid", 192'(s_axi.bvalid), 192'(0));
      aresetn_0 = 1'b1;
      for (int unsigned a = 0; a <= 128; a += 4)
         check_read(8'(a), 32'h0, $sformatf("rst_rd_%02h", a));
      check("rst_core_start", 192'(starts), 192'(0));

      // Register table
      kw = '{32'h28aed2a6, 32'h2b7e1516, 32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
      for (int unsigned k = 0; k < 3; k++) begin
         logic [7:0] b;
         b = (k == 0) ? KEY0_OFF : (k == 1) ? KEY1_OFF : KEY2_OFF;
         for (int unsigned i = 0; i < 6; i++) add(1'b1, b + 8'(i*4), kw[i], "");
         for (int unsigned i = 0; i < 6; i++) add(1'b0, b + 8'(i*4), kw[i], $sformatf("key%0d_w%0d", k, i));
      end
      add(1'b1, CT_OFF, 32'hdeadbeef, "");      add(1'b0, CT_OFF, 32'h0, "ct_ro");
      add(1'b1, DONE_OFF, 32'h1, "");           add(1'b0, DONE_OFF, 32'h0, "done_ro");
      add(1'b1, 8'h84, 32'h12345678, "");       add(1'b0, 8'h84, 32'h0, "unmapped_84");
      add(1'b0, 8'hFC, 32'h0, "unmapped_fc");
      add(1'b1, KEYSEL_OFF, 32'hffffffff, "");  add(1'b0, KEYSEL_OFF, 32'h3, "keysel_mask");
      add(1'b1, KEYSEL_OFF, 32'h0, "");         add(1'b0, KEYSEL_OFF, 32'h0, "keysel_0");
      add(1'b1, START_OFF, 32'h0, "");          add(1'b0, START_OFF, 32'h0, "start_0");
      foreach (vt[i]) begin
         if (vt[i].wr) axi_write(vt[i].addr, vt[i].data);
         else          check_read(vt[i].addr, vt[i].data, vt[i].name);
      end

      // CTR block
      pt_v = {32'h00001111, 32'h22223333, 32'h44445555, 32'h66667777};
      st_v = {32'he0370734, 32'h313198a2, 32'h885a308d, 32'h3243f6a8};
      k0_exp = 192'h2b7e1516_28aed2a6_abf71588_09cf4f3c_2b7e1516_28aed2a6;
      write_field(PT_OFF, PT_WORDS, 192'(pt_v));
      write_field(ST_OFF, ST_WORDS, 192'(st_v));
      res_val = '1;
      run_block("ctr_done");
      check("ctr_starts", 192'(starts), 192'(1));
      check("ctr_key", key_seen, k0_exp);
      check("ctr_block", 192'(blk_seen), 192'(st_v));
      check_read(DONE_OFF, 32'h1, "ctr_done_bit");
      ct_exp = {32'hffffeeee, 32'hddddcccc, 32'hbbbbaaaa, 32'h99998888};
      for (int unsigned i = 0; i < CT_WORDS; i++)
         check_read(CT_OFF + 8'(i*4), ct_exp[i*32 +: 32], $sformatf("ctr_ct_w%0d", i));
      check_read(ST_OFF, 32'h3243f6a9, "ctr_st_w0");
      check_read(ST_OFF + 8'd4, 32'h885a308d, "ctr_st_w1");

      // Spurious done while idle carries result 0: CT/ST must not move
      inject = 1'b1;
      repeat (4) @(negedge aclk_0);
      check_read(CT_OFF, 32'h99998888, "idle_done_ct");
      check_read(ST_OFF, 32'h3243f6a9, "idle_done_st");

      // Busy guard: second rising START during BUSY
      s0 = starts;
      d0 = dones;
      axi_write(START_OFF, 32'h1);
      check_read(DONE_OFF, 32'h0, "busy_done_clr");
      axi_write(START_OFF, 32'h0);
      axi_write(START_OFF, 32'h1);
      wait_dones(d0 + 1, "busy_done");
      check("busy_starts", 192'(starts), 192'(s0 + 1));
      check_read(START_OFF, 32'h1, "busy_start_reg");
      check_read(ST_OFF, 32'h3243f6aa, "busy_st_w0");
      axi_write(START_OFF, 32'h0);

      // ST wrap
      write_field(ST_OFF, ST_WORDS, 192'({128{1'b1}}));
      run_block("wrap_done");
      check("wrap_block", 192'(blk_seen), 192'({128{1'b1}}));
      for (int unsigned i = 0; i < ST_WORDS; i++)
         check_read(ST_OFF + 8'(i*4), 32'h0, $sformatf("wrap_st_w%0d", i));

      // Key select
      for (int unsigned i = 0; i < KEY_WORDS; i++) begin
         k1_v[i*32 +: 32] = 32'h11110000 + i;
         k2_v[i*32 +: 32] = 32'h2222a000 + i;
      end
      write_field(KEY1_OFF, KEY_WORDS, k1_v);
      write_field(KEY2_OFF, KEY_WORDS, k2_v);
      axi_write(KEYSEL_OFF, 32'h2);
      run_block("sel2_done");
      check("sel2_key", key_seen, k2_v);
      check_read(KEYSEL_OFF, 32'h2, "sel2_reg");
      axi_write(KEYSEL_OFF, 32'h1);
      run_block("sel1_done");
      check("sel1_key", key_seen, k1_v);
      axi_write(KEYSEL_OFF, 32'h3);
      run_block("sel3_done");
      check("sel3_key", key_seen, k0_exp);

      // Reset mid-operation; the late core_done must be ignored
      d0 = dones;
      axi_write(START_OFF, 32'h1);
      repeat (3) @(negedge aclk_0);
      aresetn_0 = 1'b0;
      repeat (2) @(negedge aclk_0);
      check("rstmid_core_start", 192'(core_start), 192'(0));
      aresetn_0 = 1'b1;
      wait_dones(d0 + 1, "rstmid_late_done");
      check_read(DONE_OFF, 32'h0, "rstmid_done");
      check_read(CT_OFF, 32'h0, "rstmid_ct");
      check_read(ST_OFF, 32'h0, "rstmid_st");
      check_read(START_OFF, 32'h0, "rstmid_start");

      check("core_start_width", 192'(pulse_err), 192'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
